apb_exe_bank: RTL and testbench
===============================

Name: apb_exe_bank

Overview:
APB slave front end for N_CH independent execution-unit channels, replacing the single-channel, fixed-address wrapper. Each channel has its own operand registers and command/status/result registers, and a busy/done tracker timed by a latency counter. The block has fixed one-wait-state APB timing, error responses, and a maskable completion interrupt. The execution units sit outside the block and connect through flattened per-channel ports.

Parameters:
DATA_WIDTH, 16, APB data width and operand/result width; must be >= STAT_WIDTH+2
ADDR_WIDTH, 16, APB address width; word addresses, not byte addresses
N_CH, 4, number of channels, 1..16
EXE_LATENCY, 2, cycles from start to result sample; must be >= 1
STAT_WIDTH, 4, width of each execution-unit status vector

Ports:
i_PCLK  in  1  clock; all logic on rising edge
i_PRESET  in  1  synchronous, active-high reset
i_PADDR  in  ADDR_WIDTH  word address
i_PSEL  in  1  APB select
i_PENABLE  in  1  APB access phase
i_PWRITE  in  1  1 = write, 0 = read
i_PWDATA  in  DATA_WIDTH  write data
o_PREADY  out  1  transfer complete, registered
o_PRDATA  out  DATA_WIDTH  read data, registered
o_PSLVERR  out  1  error response, registered
o_oper/o_argA/o_argB  out  N_CH*DATA_WIDTH each  per-channel operands; channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH]
o_start  out  N_CH  one-cycle start pulse per channel
i_result  in  N_CH*DATA_WIDTH  execution-unit results
i_status  in  N_CH*STAT_WIDTH  execution-unit status vectors
o_irq  out  1  OR over channels of (done & irq_en)

Behaviour:
- Reset (i_PRESET=1 at an edge): all outputs, operand, result, status, ctrl, busy, done and counter registers go to 0. APB FSM goes to IDLE. Reset mid-operation abandons the channel; no done is set.
- Address map: channel c = PADDR[ADDR_WIDTH-1:3], offset = PADDR[2:0].
  - 0 OPER (RW)
  - 1 ARGA (RW)
  - 2 ARGB (RW)
  - 3 CTRL (RW): bit0 start (write-1 pulse, reads 0), bit1 irq_en
  - 4 STAT (RO): bit0 busy, bit1 done, bits[STAT_WIDTH+1:2] latched status
  - 5 RESULT (RO)
  - 6, 7 reserved
- APB FSM:
  - IDLE: on PSEL&PENABLE, decode the access, commit any write side effect, and register PREADY=1 with PRDATA/PSLVERR; go to RESP.
  - RESP: PREADY, PRDATA and PSLVERR return to 0; go to IDLE.
  - Every access phase therefore lasts exactly 2 cycles. A setup phase alone (PSEL without PENABLE) has no effect.
  - PRDATA is 0 on writes and on errored reads.
- PSLVERR=1 with no side effect when any of the following holds:
  - channel >= N_CH
  - reserved offset
  - write to STAT or RESULT
  - write to OPER/ARGA/ARGB while that channel is busy
  - CTRL write with bit0=1 while that channel is busy; the whole write is ignored, irq_en unchanged
- Start: a CTRL write with bit0=1 on an idle channel does all of the following at the commit edge:
  - o_start[c] is 1 for one cycle
  - busy=1, done=0
  - counter loads EXE_LATENCY
- Completion: the counter decrements each cycle while busy. At the edge EXE_LATENCY cycles after the start edge:
  - i_result/i_status are sampled into RESULT/STAT
  - busy=0, done=1
  - channels run concurrently and independently
- Done clear: a read of RESULT clears done. If completion and the RESULT read land on the same edge, completion wins: done=1 and PRDATA returns the old result.
- Reads of RESULT while busy return the last latched result.
- Operand outputs are driven continuously from the OPER/ARGA/ARGB registers.
- o_irq is registered and updates one cycle after done or irq_en changes.
- Widths: the status field is zero-extended to DATA_WIDTH; write data is used at full width.

Test Plan:
1. Reset, then write ch0 OPER=0x0003, ARGA=0x1234, ARGB=0x00FF, and read them back -> each read returns the written value. PREADY is high exactly on the 2nd access cycle; PSLVERR=0.
2. Start ch1 with EXE_LATENCY=2 and i_result[ch1]=0xBEEF, i_status[ch1]=4'b1010 -> o_start[1] pulses for 1 cycle, STAT reads 0x0001 during busy, then 0x002A. RESULT reads 0xBEEF and a following STAT read returns 0x0028.
3. Error cases: read addr 0x0006 -> PSLVERR=1. Write 0x0005 -> PSLVERR=1. Access addr N_CH*8 -> PSLVERR=1. Write ARGA or CTRL start while busy -> PSLVERR=1 and operands unchanged.
4. Start ch0 and ch3 on back-to-back accesses -> both complete independently EXE_LATENCY cycles after their own start edges, and each latches its own i_result slice.
5. Set CTRL irq_en=1 on ch2, start it, then read RESULT -> o_irq rises one cycle after done and falls one cycle after the RESULT read.
6. Assert i_PRESET one cycle after a ch0 start -> busy=0, done=0, all registers 0, o_irq=0. No completion occurs afterwards.

Source files
------------

// File: rtl/apb_exe_bank.sv
// apb_exe_bank: APB slave front end for N_CH execution-unit channels (operands, control, status, result, irq); ports: APB slave i_P*/o_P*, per-channel flattened o_oper/o_argA/o_argB/o_start out, i_result/i_status in, o_irq out
module apb_exe_bank #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int N_CH        = 4,
  parameter int EXE_LATENCY = 2,
  parameter int STAT_WIDTH  = 4
) (
  input  logic                       i_PCLK,
  input  logic                       i_PRESET,
  input  logic [ADDR_WIDTH-1:0]      i_PADDR,
  input  logic                       i_PSEL,
  input  logic                       i_PENABLE,
  input  logic                       i_PWRITE,
  input  logic [DATA_WIDTH-1:0]      i_PWDATA,
  output logic                       o_PREADY,
  output logic [DATA_WIDTH-1:0]      o_PRDATA,
  output logic                       o_PSLVERR,
  output logic [N_CH*DATA_WIDTH-1:0] o_oper,
  output logic [N_CH*DATA_WIDTH-1:0] o_argA,
  output logic [N_CH*DATA_WIDTH-1:0] o_argB,
  output logic [N_CH-1:0]            o_start,
  input  logic [N_CH*DATA_WIDTH-1:0] i_result,
  input  logic [N_CH*STAT_WIDTH-1:0] i_status,
  output logic                       o_irq
);
  localparam int CW = N_CH > 1 ? $clog2(N_CH) : 1;
  localparam int NW = $clog2(EXE_LATENCY + 1);
  localparam int AW = ADDR_WIDTH - 3;
  typedef enum logic {IDLE, RESP} state_t;
  state_t state_q, state_d;
  logic pready_q, pready_d, pslverr_q, pslverr_d, irq_q;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d, rd;
  logic [DATA_WIDTH-1:0] oper_q [N_CH];
  logic [DATA_WIDTH-1:0] oper_d [N_CH];
  logic [DATA_WIDTH-1:0] arga_q [N_CH];
  logic [DATA_WIDTH-1:0] arga_d [N_CH];
  logic [DATA_WIDTH-1:0] argb_q [N_CH];
  logic [DATA_WIDTH-1:0] argb_d [N_CH];
  logic [DATA_WIDTH-1:0] res_q [N_CH];
  logic [DATA_WIDTH-1:0] res_d [N_CH];
  logic [STAT_WIDTH-1:0] stat_q [N_CH];
  logic [STAT_WIDTH-1:0] stat_d [N_CH];
  logic [NW-1:0] cnt_q [N_CH];
  logic [NW-1:0] cnt_d [N_CH];
  logic [N_CH-1:0] busy_q, busy_d, done_q, done_d, irq_en_q, irq_en_d, start_q, start_d;
  logic [AW-1:0] ch;
  logic [CW-1:0] ci;
  logic [2:0] off;
  logic acc, ch_ok, bsy, err;
  assign ch = i_PADDR[ADDR_WIDTH-1:3];
  assign ci = ch[CW-1:0];
  assign off = i_PADDR[2:0];
  assign acc = state_q == IDLE && i_PSEL && i_PENABLE;
  assign ch_ok = ch < AW'(N_CH);
  assign bsy = ch_ok && busy_q[ci];
  // a CTRL write that only touches irq_en is allowed while busy; one that requests a start is not
  assign err = !ch_ok || off > 3'd5 ||
               (i_PWRITE && (off >= 3'd4 || (bsy && (off != 3'd3 || i_PWDATA[0]))));
  assign rd = off == 3'd0 ? oper_q[ci] :
              off == 3'd1 ? arga_q[ci] :
              off == 3'd2 ? argb_q[ci] :
              off == 3'd3 ? DATA_WIDTH'({irq_en_q[ci], 1'b0}) :
              off == 3'd4 ? DATA_WIDTH'({stat_q[ci], done_q[ci], busy_q[ci]}) : res_q[ci];
  always_comb begin
    state_d = acc ? RESP : IDLE;
    pready_d = acc;
    pslverr_d = acc && err;
    prdata_d = acc && !err && !i_PWRITE ? rd : '0;
    oper_d = oper_q;
    arga_d = arga_q;
    argb_d = argb_q;
    res_d = res_q;
    stat_d = stat_q;
    cnt_d = cnt_q;
    busy_d = busy_q;
    done_d = done_q;
    irq_en_d = irq_en_q;
    start_d = '0;
    if (acc && !err && i_PWRITE) begin
      if (off == 3'd0) oper_d[ci] = i_PWDATA;
      if (off == 3'd1) arga_d[ci] = i_PWDATA;
      if (off == 3'd2) argb_d[ci] = i_PWDATA;
      if (off == 3'd3) begin
        irq_en_d[ci] = i_PWDATA[1];
        if (i_PWDATA[0]) begin
          start_d[ci] = 1'b1;
          busy_d[ci] = 1'b1;
          done_d[ci] = 1'b0;
          cnt_d[ci] = NW'(EXE_LATENCY);
        end
      end
    end
    if (acc && !err && !i_PWRITE && off == 3'd5) done_d[ci] = 1'b0;
    // completion is evaluated last so it overrides a RESULT read clearing done on the same edge
    for (int c = 0; c < N_CH; c++)
      if (busy_q[c]) begin
        cnt_d[c] = cnt_q[c] - NW'(1);
        if (cnt_q[c] == NW'(1)) begin
          busy_d[c] = 1'b0;
          done_d[c] = 1'b1;
          res_d[c] = i_result[c*DATA_WIDTH +: DATA_WIDTH];
          stat_d[c] = i_status[c*STAT_WIDTH +: STAT_WIDTH];
        end
      end
  end
  always_ff @(posedge i_PCLK) begin
    if (i_PRESET) begin
      state_q <= IDLE;
      pready_q <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q <= '0;
      oper_q <= '{default: '0};
      arga_q <= '{default: '0};
      argb_q <= '{default: '0};
      res_q <= '{default: '0};
      stat_q <= '{default: '0};
      cnt_q <= '{default: '0};
      busy_q <= '0;
      done_q <= '0;
      irq_en_q <= '0;
      start_q <= '0;
      irq_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pready_q <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q <= prdata_d;
      oper_q <= oper_d;
      arga_q <= arga_d;
      argb_q <= argb_d;
      res_q <= res_d;
      stat_q <= stat_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      irq_en_q <= irq_en_d;
      start_q <= start_d;
      irq_q <= |(done_q & irq_en_q);
    end
  end
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign o_oper[g*DATA_WIDTH +: DATA_WIDTH] = oper_q[g];
    assign o_argA[g*DATA_WIDTH +: DATA_WIDTH] = arga_q[g];
    assign o_argB[g*DATA_WIDTH +: DATA_WIDTH] = argb_q[g];
  end
  assign o_start = start_q;
  assign o_PREADY = pready_q;
  assign o_PRDATA = prdata_q;
  assign o_PSLVERR = pslverr_q;
  assign o_irq = irq_q;
endmodule

// File: tb/tb_apb_exe_bank.sv
// tb_apb_exe_bank: randomized scoreboard bench for apb_exe_bank against a transaction-level channel model
module tb_apb_exe_bank;
  localparam int DW = 16, AW = 16, N = 4, L = 6, SW = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [AW-1:0] paddr = '0;
  logic psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [DW-1:0] pwdata = '0;
  logic pready, pslverr, irq;
  logic [DW-1:0] prdata;
  logic [N*DW-1:0] oper, arga, argb;
  logic [N*DW-1:0] result = '0;
  logic [N*SW-1:0] status = '0;
  logic [N-1:0] start;
  apb_exe_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_CH(N), .EXE_LATENCY(L), .STAT_WIDTH(SW)) dut (
    .i_PCLK(clk), .i_PRESET(rst), .i_PADDR(paddr), .i_PSEL(psel), .i_PENABLE(penable),
    .i_PWRITE(pwrite), .i_PWDATA(pwdata), .o_PREADY(pready), .o_PRDATA(prdata), .o_PSLVERR(pslverr),
    .o_oper(oper), .o_argA(arga), .o_argB(argb), .o_start(start), .i_result(result),
    .i_status(status), .o_irq(irq)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [DW-1:0] m_oper [N], m_arga [N], m_argb [N], m_res [N], m_pres [N];
  logic [SW-1:0] m_stat [N], m_pstat [N];
  bit m_busy [N], m_done [N], m_irqen [N];
  int m_dcyc [N], m_scyc [N];
  bit irq_prev;
  typedef struct {logic [DW-1:0] d; logic e; logic [AW-1:0] a;} resp_t;
  resp_t sbq [$];
  int checks = 0, failures = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask
  function automatic void model_reset();
    for (int c = 0; c < N; c++) begin
      m_oper[c] = '0; m_arga[c] = '0; m_argb[c] = '0; m_res[c] = '0; m_pres[c] = '0;
      m_stat[c] = '0; m_pstat[c] = '0; m_busy[c] = 0; m_done[c] = 0; m_irqen[c] = 0;
      m_dcyc[c] = 0; m_scyc[c] = -100;
    end
    irq_prev = 0;
    sbq.delete();
  endfunction
  function automatic void model_apply(input int t);
    for (int c = 0; c < N; c++)
      if (m_busy[c] && m_dcyc[c] <= t) begin
        m_busy[c] = 0; m_done[c] = 1; m_res[c] = m_pres[c]; m_stat[c] = m_pstat[c];
      end
  endfunction
  always @(negedge clk) if (!rst) begin
    logic [N-1:0] es;
    bit irq_now;
    resp_t r;
    model_apply(cyc);
    for (int c = 0; c < N; c++) es[c] = m_scyc[c] == cyc;
    chk("o_start", 32'(start), 32'(es));
    chk("o_irq", 32'(irq), 32'(irq_prev));
    irq_now = 0;
    for (int c = 0; c < N; c++) irq_now |= m_done[c] & m_irqen[c];
    irq_prev = irq_now;
    if (pready) begin
      if (sbq.size() == 0) chk("pready_unexpected", 32'(pready), 32'(0));
      else begin
        r = sbq.pop_front();
        chk($sformatf("prdata@%h", r.a), 32'(prdata), 32'(r.d));
        chk($sformatf("pslverr@%h", r.a), 32'(pslverr), 32'(r.e));
      end
    end else chk("resp_idle", 32'({prdata, pslverr}), 32'(0));
  end
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic apb(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    int t, c;
    logic [2:0] o;
    bit ok, b, e;
    logic [DW-1:0] rd;
    resp_t r;
    psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = wd;
    @(posedge clk); #1 penable = 1;
    @(posedge clk); #1 t = cyc;
    model_apply(t - 1);
    c = int'(a >> 3);
    o = a[2:0];
    ok = c < N;
    b = ok ? m_busy[c] : 0;
    e = !ok || o >= 6;
    if (!e && wr) e = o == 4 || o == 5 || (o <= 2 && b) || (o == 3 && wd[0] && b);
    rd = '0;
    if (!e && !wr)
      case (o)
        0: rd = m_oper[c];
        1: rd = m_arga[c];
        2: rd = m_argb[c];
        3: rd = m_irqen[c] ? DW'(2) : DW'(0);
        4: rd = DW'({m_stat[c], 1'(m_done[c]), 1'(m_busy[c])});
        default: begin rd = m_res[c]; m_done[c] = 0; end
      endcase
    if (!e && wr)
      case (o)
        0: m_oper[c] = wd;
        1: m_arga[c] = wd;
        2: m_argb[c] = wd;
        default: begin
          m_irqen[c] = wd[1];
          if (wd[0]) begin
            m_busy[c] = 1; m_done[c] = 0; m_dcyc[c] = t + L; m_scyc[c] = t;
            m_pres[c] = result[c*DW +: DW]; m_pstat[c] = status[c*SW +: SW];
          end
        end
      endcase
    model_apply(t);
    r.d = rd; r.e = e; r.a = a;
    sbq.push_back(r);
    @(posedge clk); #1 psel = 0; penable = 0;
    chk("pready_missing", 32'(sbq.size()), 32'(0));
    sbq.delete();
  endtask
  task automatic setup_only(input logic [AW-1:0] a, input logic [DW-1:0] wd);
    psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = wd;
    @(posedge clk); #1 psel = 0;
  endtask
  task automatic set_unit(input int c, input logic [DW-1:0] r, input logic [SW-1:0] s);
    result[c*DW +: DW] = r;
    status[c*SW +: SW] = s;
  endtask
  task automatic do_reset();
    rst = 1;
    @(posedge clk); #1 model_reset();
    rst = 0;
  endtask
  initial begin
    int c, o, n;
    bit wr;
    logic [DW-1:0] wd;
    model_reset();
    repeat (3) @(posedge clk);
    #1 model_reset();
    rst = 0;
    chk("reset_pready", 32'(pready), 32'(0));
    chk("reset_irq", 32'(irq), 32'(0));
    chk("reset_oper", 32'(oper), 32'(0));
    for (int a = 0; a < 6; a++) apb(0, AW'(a), '0);
    apb(1, 16'h0000, 16'h0003);
    apb(1, 16'h0001, 16'h1234);
    apb(1, 16'h0002, 16'h00FF);
    for (int a = 0; a < 3; a++) apb(0, AW'(a), '0);
    chk("o_oper0", 32'(oper[DW-1:0]), 32'h0003);
    chk("o_argA0", 32'(arga[DW-1:0]), 32'h1234);
    chk("o_argB0", 32'(argb[DW-1:0]), 32'h00FF);
    set_unit(1, 16'hBEEF, 4'b1010);
    apb(1, 16'h000B, 16'h0001);
    apb(0, 16'h000C, '0);
    apb(1, 16'h0009, 16'h5555);
    apb(1, 16'h000B, 16'h0001);
    chk("argA1_kept", 32'(arga[DW +: DW]), 32'h0);
    tick(L);
    apb(0, 16'h000C, '0);
    apb(0, 16'h000D, '0);
    apb(0, 16'h000C, '0);
    apb(0, 16'h0006, '0);
    apb(1, 16'h0005, 16'h1111);
    apb(0, AW'(N * 8), '0);
    apb(1, AW'(N * 8 + 1), 16'h2222);
    set_unit(0, 16'hA0A0, 4'h3);
    set_unit(3, 16'h3C3C, 4'h5);
    apb(1, 16'h0003, 16'h0001);
    apb(1, 16'h001B, 16'h0001);
    tick(L);
    apb(0, 16'h0005, '0);
    apb(0, 16'h001D, '0);
    apb(0, 16'h001C, '0);
    apb(1, 16'h0013, 16'h0002);
    set_unit(2, 16'h7777, 4'h9);
    apb(1, 16'h0013, 16'h0003);
    tick(L + 2);
    chk("irq_high", 32'(irq), 32'(1));
    apb(0, 16'h0015, '0);
    tick(2);
    chk("irq_low", 32'(irq), 32'(0));
    apb(1, 16'h0003, 16'h0003);
    do_reset();
    chk("rst_pready", 32'(pready), 32'(0));
    chk("rst_start", 32'(start), 32'(0));
    chk("rst_argA", 32'(arga), 32'(0));
    tick(L + 2);
    chk("rst_irq", 32'(irq), 32'(0));
    for (int a = 0; a < 6; a++) apb(0, AW'(a), '0);
    for (int i = 0; i < 500; i++) begin
      c = $urandom_range(0, N);
      o = $urandom_range(0, 7);
      wr = 1'($urandom_range(0, 1));
      wd = DW'($urandom);
      if (c < N) begin
        model_apply(cyc);
        if (!m_busy[c]) set_unit(c, DW'($urandom), SW'($urandom));
      end
      if ($urandom_range(0, 9) == 0) setup_only(AW'(c * 8 + o), wd);
      apb(wr, AW'(c * 8 + o), wd);
      n = $urandom_range(0, 4);
      tick(n);
      if (i == 250) do_reset();
    end
    tick(L + 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
